variable_latency_bank_responder: RTL
====================================

# variable_latency_bank_responder

Target-side endpoint of the variable-latency TCDM interconnect: accepts one request per cycle from an interconnect output port and drives a fixed-latency SRAM bank. It returns exactly one response per request, tagged with the originating initiator index, over a valid/ready handshake that may back-pressure. Credit-based admission plus a fall-through response FIFO guarantee that SRAM read data is never lost while the interconnect stalls.

## Interface
- NumIn, 32, number of initiators; tag width IniAddrWidth = $clog2(NumIn)
- AddrMemWidth, 12, word address bits per bank
- DataWidth, 32, data word width
- BeWidth, DataWidth/8, byte-enable width
- MemLatency, 1, SRAM read latency in cycles (>= 1)
- RespFifoDepth, 2, response buffer depth (>= 1); full throughput requires >= MemLatency+1
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_ini_addr_i  in  IniAddrWidth  initiator tag
- req_tgt_addr_i  in  AddrMemWidth  word address in bank
- req_wen_i  in  1  write enable
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enable
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_ini_addr_o  out  IniAddrWidth  initiator tag of response
- resp_rdata_o  out  DataWidth  read data (0 for writes)
- mem_req_o  out  1  SRAM access strobe
- mem_addr_o  out  AddrMemWidth  SRAM address
- mem_wen_o  out  1  SRAM write enable
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enable
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after mem_req_o

## Operation
- Credit counter `outstanding` (width $clog2(RespFifoDepth+1)) = requests accepted but whose response has not yet handshaken.
- req_ready_o = (outstanding < RespFifoDepth); depends on registered state only (no combinational path from resp_ready_i).
- Accept = req_valid_i & req_ready_o; mem_req_o = accept; mem_addr/wen/wdata/be pass straight through from req_*.
- Accept: outstanding+1; response handshake (resp_valid_o & resp_ready_i): outstanding-1; both in the same cycle: unchanged. Never exceeds RespFifoDepth, never underflows.
- Tag pipeline: MemLatency stages of {valid, ini_addr, wen}, advancing every cycle unconditionally (SRAM cannot stall).
- At pipeline exit (valid): response word = {ini_addr, wen ? '0 : mem_rdata_i}.
- Response FIFO, fall-through: if FIFO empty and resp_ready_i=1, the exit word is presented and consumed directly without being stored; otherwise it is pushed. resp_valid_o = !empty | exit_valid; output = FIFO head when non-empty, else exit word.
- Order preserved: responses leave in acceptance order.
- Credit guarantees FIFO never overflows; push when full is an assertion failure.
- Reset (async, any time): outstanding=0, all pipeline valids=0, FIFO empty; in-flight requests are discarded, no responses are produced for them.

## Timing
- Reset values: req_ready_o=1, resp_valid_o=0, resp_ini_addr_o=0, resp_rdata_o=0; mem_req_o=0 unless req_valid_i asserted (upstream holds valid low in reset).
- Request accepted in cycle t -> mem_req_o in t -> response valid in cycle t+MemLatency (unstalled).
- Unstalled throughput: 1 request/cycle when RespFifoDepth >= MemLatency+1.
- Stall: resp_valid_o stays high, resp_ini_addr_o/resp_rdata_o stable until handshake.
- Credit freed by a handshake in cycle t enables req_ready_o in t+1.

## Test plan
- MemLatency=1, Depth=2, resp_ready_i=1: reads to addr 0..7 with tags 0..7 back-to-back -> req_ready_o stays 1, response k at cycle k+1 with tag k and stored data; one response per cycle.
- resp_ready_i=0, 5 requests offered -> 2 accepted, req_ready_o=0 from cycle 2; raise resp_ready_i -> both responses in order, req_ready_o=1 the cycle after first handshake.
- Write addr 5 data 0xDEADBEEF be 0xF tag 3, then read addr 5 tag 4 -> write response tag 3 rdata 0; read response tag 4 rdata 0xDEADBEEF.
- Partial write be=0x1 data 0x000000AA over 0xDEADBEEF, read back -> 0xDEADBEAA.
- Full counter (outstanding=2) with simultaneous handshake and req_valid_i -> no accept that cycle (ready=0), outstanding=1 next cycle, accept then.
- MemLatency=3, Depth=4, assert rst_ni low with 3 requests in flight -> after release resp_valid_o=0, no stale responses, req_ready_o=1.

Source files
------------

// File: rtl/variable_latency_bank_responder.sv
// Target-side TCDM bank endpoint: credit-gated request admission, fixed-latency
// SRAM tag pipeline and a fall-through response FIFO that absorbs back-pressure.

module variable_latency_bank_responder_chk #(
    parameter int unsigned RespFifoDepth = 2,
    parameter int unsigned CntWidth      = 2
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic                push_i,
    input logic                full_i,
    input logic                pop_i,
    input logic                empty_i,
    input logic [CntWidth-1:0] outstanding_i
);

    // Credit accounting must keep the response FIFO from overflowing.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_i));

    // Popping an empty FIFO would mean a response without a request.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_i));

    // Outstanding credits are bounded by the buffer depth.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     outstanding_i <= CntWidth'(RespFifoDepth));

endmodule

module variable_latency_bank_responder #(
    parameter int unsigned NumIn         = 32,
    parameter int unsigned AddrMemWidth  = 12,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned BeWidth       = DataWidth / 8,
    parameter int unsigned MemLatency    = 1,
    parameter int unsigned RespFifoDepth = 2,
    localparam int unsigned IniAddrWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IniAddrWidth-1:0] req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IniAddrWidth-1:0] resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    mem_req_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic                    mem_wen_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int unsigned CntWidth  = $clog2(RespFifoDepth + 1);
    localparam int unsigned PtrWidth  = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam int unsigned RespWidth = IniAddrWidth + DataWidth;

    // Circular pointer advance for a depth that need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(RespFifoDepth - 1)) begin
            return {PtrWidth{1'b0}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    logic [CntWidth-1:0]                       outstanding_q, outstanding_d;
    logic [MemLatency-1:0]                     pipe_valid_q, pipe_valid_d;
    logic [MemLatency-1:0]                     pipe_wen_q, pipe_wen_d;
    logic [MemLatency-1:0][IniAddrWidth-1:0]   pipe_ini_q, pipe_ini_d;
    logic [RespWidth-1:0]                      fifo_mem_q [RespFifoDepth];
    logic [RespWidth-1:0]                      fifo_mem_d [RespFifoDepth];
    logic [PtrWidth-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]                       fifo_cnt_q, fifo_cnt_d;

    logic                 accept_s, resp_hs_s, push_s, pop_s;
    logic                 fifo_empty_s, fifo_full_s, exit_valid_s;
    logic [RespWidth-1:0] exit_word_s;

    // Ready depends only on the registered credit count.
    assign req_ready_o  = (outstanding_q < CntWidth'(RespFifoDepth));
    assign accept_s     = req_valid_i & req_ready_o;

    // SRAM port is a straight pass-through of the accepted request.
    assign mem_req_o    = accept_s;
    assign mem_addr_o   = req_tgt_addr_i;
    assign mem_wen_o    = req_wen_i;
    assign mem_wdata_o  = req_wdata_i;
    assign mem_be_o     = req_be_i;

    assign fifo_empty_s = (fifo_cnt_q == {CntWidth{1'b0}});
    assign fifo_full_s  = (fifo_cnt_q == CntWidth'(RespFifoDepth));
    assign exit_valid_s = pipe_valid_q[MemLatency-1];
    assign exit_word_s  = {pipe_ini_q[MemLatency-1],
                           pipe_wen_q[MemLatency-1] ? {DataWidth{1'b0}} : mem_rdata_i};

    assign resp_valid_o = !fifo_empty_s | exit_valid_s;
    assign resp_hs_s    = resp_valid_o & resp_ready_i;
    // Exit word bypasses storage only when nothing older is queued and it is taken now.
    assign push_s       = exit_valid_s & !(fifo_empty_s & resp_ready_i);
    assign pop_s        = !fifo_empty_s & resp_ready_i;

    // Response mux: oldest buffered word first, else the pipeline exit, else zero.
    always_comb begin
        {resp_ini_addr_o, resp_rdata_o} = {RespWidth{1'b0}};
        if (!fifo_empty_s) begin
            {resp_ini_addr_o, resp_rdata_o} = fifo_mem_q[rd_ptr_q];
        end else if (exit_valid_s) begin
            {resp_ini_addr_o, resp_rdata_o} = exit_word_s;
        end else begin
            {resp_ini_addr_o, resp_rdata_o} = {RespWidth{1'b0}};
        end
    end

    // Credit counter: +1 per accept, -1 per response handshake.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_s && !resp_hs_s) begin
            outstanding_d = outstanding_q + CntWidth'(1);
        end else if (!accept_s && resp_hs_s) begin
            outstanding_d = outstanding_q - CntWidth'(1);
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Tag pipeline shifts every cycle in lock-step with the SRAM latency.
    always_comb begin
        pipe_valid_d    = pipe_valid_q;
        pipe_wen_d      = pipe_wen_q;
        pipe_ini_d      = pipe_ini_q;
        pipe_valid_d[0] = accept_s;
        pipe_wen_d[0]   = req_wen_i;
        pipe_ini_d[0]   = req_ini_addr_i;
        for (int k = 1; k < int'(MemLatency); k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_wen_d[k]   = pipe_wen_q[k-1];
            pipe_ini_d[k]   = pipe_ini_q[k-1];
        end
    end

    // Response FIFO next state: storage write, pointers and occupancy.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = exit_word_s;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + CntWidth'(push_s) - CntWidth'(pop_s);
    end

    // State registers; reset drops in-flight requests and empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= {CntWidth{1'b0}};
            pipe_valid_q  <= {MemLatency{1'b0}};
            pipe_wen_q    <= {MemLatency{1'b0}};
            pipe_ini_q    <= {(MemLatency*IniAddrWidth){1'b0}};
            wr_ptr_q      <= {PtrWidth{1'b0}};
            rd_ptr_q      <= {PtrWidth{1'b0}};
            fifo_cnt_q    <= {CntWidth{1'b0}};
            for (int k = 0; k < int'(RespFifoDepth); k++) begin
                fifo_mem_q[k] <= {RespWidth{1'b0}};
            end
        end else begin
            outstanding_q <= outstanding_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_wen_q    <= pipe_wen_d;
            pipe_ini_q    <= pipe_ini_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            fifo_mem_q    <= fifo_mem_d;
        end
    end

    variable_latency_bank_responder_chk #(
        .RespFifoDepth (RespFifoDepth),
        .CntWidth      (CntWidth)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push_s),
        .full_i        (fifo_full_s),
        .pop_i         (pop_s),
        .empty_i       (fifo_empty_s),
        .outstanding_i (outstanding_q)
    );

endmodule
